// File: rtl/instruction_loader.sv
// Assembles big-endian 32-bit instruction words from UART bytes and drives a
// three-phase (setup / write / hold) debug write port into instruction memory.
module instruction_loader #(
   parameter int                   INST_BITS = 32,
   parameter int                   MAX_INSTS = 64,
   parameter logic [INST_BITS-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_start,
   input  logic [7:0]           i_rx_data,
   input  logic                 i_rx_valid,
   output logic [INST_BITS-1:0] o_dbg_addr,
   output logic [INST_BITS-1:0] o_dbg_inst,
   output logic                 o_dbg_wr_en,
   output logic                 o_busy,
   output logic                 o_done,
   output logic [7:0]           o_inst_count,
   output logic                 o_overflow,
   output logic                 o_rx_lost
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_RECV  = 3'd1;
   localparam logic [2:0] ST_SETUP = 3'd2;
   localparam logic [2:0] ST_WRITE = 3'd3;
   localparam logic [2:0] ST_HOLD  = 3'd4;
   localparam logic [2:0] ST_DONE  = 3'd5;

   localparam logic [7:0] MAX_CNT = 8'(MAX_INSTS);

   logic [2:0]           state_r;
   logic [2:0]           state_s;
   logic [1:0]           byte_cnt_r;
   logic [INST_BITS-1:0] word_r;
   logic [INST_BITS-1:0] addr_r;
   logic [INST_BITS-1:0] word_shift_s;
   logic [7:0]           cnt_next_s;
   logic                 halt_s;
   logic                 full_s;

   // Next-state decode and word/count helpers
   always_comb begin
      word_shift_s = {word_r[INST_BITS-9:0], i_rx_data};
      halt_s       = (word_r == HALT_WORD);
      if (o_inst_count >= MAX_CNT) begin
         cnt_next_s = MAX_CNT;
      end else begin
         cnt_next_s = o_inst_count + 8'd1;
      end
      full_s  = (cnt_next_s == MAX_CNT);
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (i_start) state_s = ST_RECV;
            else         state_s = ST_IDLE;
         end
         ST_RECV: begin
            if (i_rx_valid && (byte_cnt_r == 2'd3)) state_s = ST_SETUP;
            else                                    state_s = ST_RECV;
         end
         ST_SETUP: state_s = ST_WRITE;
         ST_WRITE: state_s = ST_HOLD;
         ST_HOLD: begin
            if (halt_s || full_s) state_s = ST_DONE;
            else                  state_s = ST_RECV;
         end
         ST_DONE: begin
            if (i_start) state_s = ST_RECV;
            else         state_s = ST_DONE;
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // State, datapath and registered outputs
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_r      <= ST_IDLE;
         byte_cnt_r   <= 2'd0;
         word_r       <= '0;
         addr_r       <= '0;
         o_dbg_addr   <= '0;
         o_dbg_inst   <= '0;
         o_dbg_wr_en  <= 1'b0;
         o_busy       <= 1'b0;
         o_done       <= 1'b0;
         o_inst_count <= 8'd0;
         o_overflow   <= 1'b0;
         o_rx_lost    <= 1'b0;
      end else begin
         state_r     <= state_s;
         o_dbg_wr_en <= (state_s == ST_WRITE);
         o_done      <= (state_s == ST_DONE);
         o_busy      <= (state_s == ST_RECV) || (state_s == ST_SETUP) ||
                        (state_s == ST_WRITE) || (state_s == ST_HOLD);
         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (i_start) begin
                  byte_cnt_r   <= 2'd0;
                  word_r       <= '0;
                  addr_r       <= '0;
                  o_dbg_addr   <= '0;
                  o_dbg_inst   <= '0;
                  o_inst_count <= 8'd0;
                  o_overflow   <= 1'b0;
                  o_rx_lost    <= 1'b0;
               end
            end
            ST_RECV: begin
               if (i_rx_valid) begin
                  word_r     <= word_shift_s;
                  byte_cnt_r <= byte_cnt_r + 2'd1;
                  // The 4th byte latches the write-port address/data for the whole write sequence
                  if (byte_cnt_r == 2'd3) begin
                     o_dbg_inst <= word_shift_s;
                     o_dbg_addr <= addr_r;
                  end
               end
            end
            ST_SETUP, ST_WRITE: begin
               if (i_rx_valid) o_rx_lost <= 1'b1;
            end
            ST_HOLD: begin
               if (i_rx_valid) o_rx_lost <= 1'b1;
               o_inst_count <= cnt_next_s;
               addr_r       <= addr_r + INST_BITS'(4);
               if (!halt_s && full_s) o_overflow <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule
